// File: rtl/motor_pwm_driver_if.sv
// Command and H-bridge pin bundle between the motion controller and the PWM driver.
// The master drives the motion command; the slave drives the bridge pins.
interface motor_pwm_driver_if;
   logic [3:0]  Direction;
   logic [11:0] DutyA;
   logic [11:0] DutyB;
   logic [3:0]  hbridge_in;
   logic        pwm_a;
   logic        pwm_b;
   logic        dead_active;
   logic        shoot_fault;

   modport master (
      output Direction, DutyA, DutyB,
      input  hbridge_in, pwm_a, pwm_b, dead_active, shoot_fault
   );

   modport slave (
      input  Direction, DutyA, DutyB,
      output hbridge_in, pwm_a, pwm_b, dead_active, shoot_fault
   );
endinterface

// File: rtl/motor_pwm_driver.sv
// Two-channel H-bridge driver: edge-aligned PWM, soft-start duty ramp,
// dead time on direction reversal, and shoot-through pair blocking.
module motor_pwm_driver #(
   parameter int PWM_PERIOD  = 4096,
   parameter int RAMP_STEP   = 512,
   parameter int DEAD_CYCLES = 1000
) (
   input logic               clk,
   input logic               rst_n,
   motor_pwm_driver_if.slave bus
);
   localparam int CW = $clog2(PWM_PERIOD);
   localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(PWM_PERIOD - 1);
   localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYCLES - 1);
   localparam logic [12:0]   STEP      = 13'(RAMP_STEP);

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_DEAD = 1'b1
   } state_t;

   function automatic logic [1:0] sanitize_pair(input logic [1:0] pair);
      sanitize_pair = (pair == 2'b11) ? 2'b00 : pair;
   endfunction

   // Increases are rate limited; decreases (and equal targets) land at once.
   function automatic logic [12:0] ramp_next(input logic [12:0] cur, input logic [12:0] tgt);
      logic [12:0] diff;
      diff = tgt - cur;
      if ((tgt > cur) && (diff > STEP)) begin
         ramp_next = cur + STEP;
      end else begin
         ramp_next = tgt;
      end
   endfunction

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    dir_act_q, dir_act_d;
   logic [3:0]    pend_q, pend_d;
   logic [DW-1:0] dead_cnt_q, dead_cnt_d;
   logic [12:0]   duty_cur_a_q, duty_cur_a_d;
   logic [12:0]   duty_cur_b_q, duty_cur_b_d;
   logic          pwm_a_q, pwm_a_d;
   logic          pwm_b_q, pwm_b_d;
   logic          dead_active_q, dead_active_d;
   logic          shoot_fault_q, shoot_fault_d;

   logic [3:0]    req_s;
   logic          wrap_s;
   logic [12:0]   cnt_ext_s;

   // Next-state logic: sanitize, period counter, ramp, direction FSM, PWM compare.
   always_comb begin
      req_s         = {sanitize_pair(bus.Direction[3:2]), sanitize_pair(bus.Direction[1:0])};
      shoot_fault_d = (bus.Direction[3:2] == 2'b11) || (bus.Direction[1:0] == 2'b11);
      wrap_s        = (cnt_q == CNT_LAST);
      cnt_ext_s     = 13'(cnt_q);
      cnt_d         = wrap_s ? {CW{1'b0}} : cnt_q + CW'(1);

      state_d      = state_q;
      dir_act_d    = dir_act_q;
      pend_d       = pend_q;
      dead_cnt_d   = dead_cnt_q;
      duty_cur_a_d = duty_cur_a_q;
      duty_cur_b_d = duty_cur_b_q;

      if ((state_q != ST_RUN) || (dir_act_q == 4'b0000)) begin
         duty_cur_a_d = 13'd0;
         duty_cur_b_d = 13'd0;
      end else if (wrap_s) begin
         duty_cur_a_d = ramp_next(duty_cur_a_q, {1'b0, bus.DutyA});
         duty_cur_b_d = ramp_next(duty_cur_b_q, {1'b0, bus.DutyB});
      end else begin
         duty_cur_a_d = duty_cur_a_q;
         duty_cur_b_d = duty_cur_b_q;
      end

      // Direction changes override the ramp result, so a reversal on the wrap clock clears duty.
      case (state_q)
         ST_RUN: begin
            if (req_s == dir_act_q) begin
               dir_act_d = dir_act_q;
            end else if ((req_s == 4'b0000) || (dir_act_q == 4'b0000)) begin
               dir_act_d    = req_s;
               duty_cur_a_d = 13'd0;
               duty_cur_b_d = 13'd0;
            end else begin
               state_d      = ST_DEAD;
               pend_d       = req_s;
               dead_cnt_d   = DEAD_LOAD;
               dir_act_d    = 4'b0000;
               duty_cur_a_d = 13'd0;
               duty_cur_b_d = 13'd0;
            end
         end
         ST_DEAD: begin
            if (req_s == 4'b0000) begin
               state_d   = ST_RUN;
               dir_act_d = 4'b0000;
            end else if (req_s != pend_q) begin
               pend_d     = req_s;
               dead_cnt_d = DEAD_LOAD;
            end else if (dead_cnt_q == {DW{1'b0}}) begin
               state_d   = ST_RUN;
               dir_act_d = pend_q;
            end else begin
               dead_cnt_d = dead_cnt_q - DW'(1);
            end
         end
         default: begin
            state_d   = ST_RUN;
            dir_act_d = 4'b0000;
         end
      endcase

      // Gate on the next direction so PWM drops together with the bridge pins.
      pwm_a_d       = (state_d == ST_RUN) && (dir_act_d[3:2] != 2'b00) && (cnt_ext_s < duty_cur_a_q);
      pwm_b_d       = (state_d == ST_RUN) && (dir_act_d[1:0] != 2'b00) && (cnt_ext_s < duty_cur_b_q);
      dead_active_d = (state_d == ST_DEAD);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_RUN;
         cnt_q         <= {CW{1'b0}};
         dir_act_q     <= 4'b0000;
         pend_q        <= 4'b0000;
         dead_cnt_q    <= {DW{1'b0}};
         duty_cur_a_q  <= 13'd0;
         duty_cur_b_q  <= 13'd0;
         pwm_a_q       <= 1'b0;
         pwm_b_q       <= 1'b0;
         dead_active_q <= 1'b0;
         shoot_fault_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         dir_act_q     <= dir_act_d;
         pend_q        <= pend_d;
         dead_cnt_q    <= dead_cnt_d;
         duty_cur_a_q  <= duty_cur_a_d;
         duty_cur_b_q  <= duty_cur_b_d;
         pwm_a_q       <= pwm_a_d;
         pwm_b_q       <= pwm_b_d;
         dead_active_q <= dead_active_d;
         shoot_fault_q <= shoot_fault_d;
      end
   end

   assign bus.hbridge_in  = dir_act_q;
   assign bus.pwm_a       = pwm_a_q;
   assign bus.pwm_b       = pwm_b_q;
   assign bus.dead_active = dead_active_q;
   assign bus.shoot_fault = shoot_fault_q;
endmodule

// File: tb/tb_motor_pwm_driver.sv
// Directed bench for motor_pwm_driver with PWM_PERIOD=100, RAMP_STEP=40, DEAD_CYCLES=20.
module tb_motor_pwm_driver;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;
   int   t;
   int   ha;
   int   hb;
   int   bad;

   motor_pwm_driver_if bus();

   motor_pwm_driver #(
      .PWM_PERIOD  (100),
      .RAMP_STEP   (40),
      .DEAD_CYCLES (20)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0d)", tag, obs, exp, t);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      t++;
   endtask

   task automatic run(input int n, output int ca, output int cb);
      ca = 0;
      cb = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (bus.pwm_a === 1'b1) ca++;
         if (bus.pwm_b === 1'b1) cb++;
      end
   endtask

   task automatic align(output int ca, output int cb);
      run((100 - (t % 100)) % 100, ca, cb);
   endtask

   task automatic set_cmd(input logic [3:0] dir, input logic [11:0] da, input logic [11:0] db);
      bus.Direction = dir;
      bus.DutyA     = da;
      bus.DutyB     = db;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      t        = 0;
      rst_n    = 1'b0;
      set_cmd(4'b0110, 12'd100, 12'd100);
      @(negedge clk);
      @(negedge clk);
      chk("rst_hbridge", bus.hbridge_in, 4'b0000);
      chk("rst_pwm", {bus.pwm_a, bus.pwm_b}, 2'b00);
      chk("rst_flags", {bus.dead_active, bus.shoot_fault}, 2'b00);
      rst_n = 1'b1;
      t     = 0;

      // 1. soft start
      tick();
      chk("ss_hbridge_clk1", bus.hbridge_in, 4'b0110);
      chk("ss_pwm_clk1", {bus.pwm_a, bus.pwm_b}, 2'b00);
      run(99, ha, hb);
      chk("ss_p1_a", ha, 0);
      chk("ss_p1_b", hb, 0);
      run(100, ha, hb);
      chk("ss_p2_a", ha, 40);
      chk("ss_p2_b", hb, 40);
      run(100, ha, hb);
      chk("ss_p3_a", ha, 80);
      chk("ss_p3_b", hb, 80);
      run(100, ha, hb);
      chk("ss_p4_a", ha, 100);
      run(100, ha, hb);
      chk("ss_p5_a", ha, 100);
      chk("ss_p5_b", hb, 100);

      // 2. reversal mid-period
      run(50, ha, hb);
      bus.Direction = 4'b1001;
      bad = 0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (bus.hbridge_in !== 4'b0000 || bus.dead_active !== 1'b1 ||
             bus.pwm_a !== 1'b0 || bus.pwm_b !== 1'b0) bad++;
      end
      chk("rev_dead_window_bad", bad, 0);
      tick();
      chk("rev_hbridge", bus.hbridge_in, 4'b1001);
      chk("rev_dead_fall", bus.dead_active, 1'b0);
      align(ha, hb);
      chk("rev_partial_a", ha, 0);
      run(100, ha, hb);
      chk("rev_p1_a", ha, 40);
      run(100, ha, hb);
      chk("rev_p2_b", hb, 80);
      run(100, ha, hb);
      chk("rev_p3_a", ha, 100);

      // 3. change during DEAD, then stop during DEAD
      bus.Direction = 4'b0110;
      run(10, ha, hb);
      chk("dd_dead_10", bus.dead_active, 1'b1);
      bus.Direction = 4'b0101;
      bad = 0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (bus.hbridge_in !== 4'b0000 || bus.dead_active !== 1'b1) bad++;
      end
      chk("dd_extended_bad", bad, 0);
      tick();
      chk("dd_hbridge_21", bus.hbridge_in, 4'b0101);
      chk("dd_dead_fall_21", bus.dead_active, 1'b0);
      bus.Direction = 4'b1010;
      tick();
      chk("dd2_dead_rise", bus.dead_active, 1'b1);
      run(4, ha, hb);
      bus.Direction = 4'b0000;
      tick();
      chk("dd2_stop_hbridge", bus.hbridge_in, 4'b0000);
      chk("dd2_stop_dead", bus.dead_active, 1'b0);

      // 4. illegal encoding
      set_cmd(4'b1101, 12'd50, 12'd50);
      tick();
      chk("ill_fault", bus.shoot_fault, 1'b1);
      chk("ill_hbridge", bus.hbridge_in, 4'b0001);
      align(ha, hb);
      chk("ill_partial_b", hb, 0);
      run(100, ha, hb);
      chk("ill_p1_a", ha, 0);
      chk("ill_p1_b", hb, 40);
      run(100, ha, hb);
      chk("ill_p2_b", hb, 50);
      run(100, ha, hb);
      chk("ill_p3_a", ha, 0);
      chk("ill_p3_b", hb, 50);
      chk("ill_fault_held", bus.shoot_fault, 1'b1);
      bus.Direction = 4'b0000;
      tick();
      chk("ill_fault_clear", bus.shoot_fault, 1'b0);

      // 5. duty edges
      set_cmd(4'b0110, 12'd100, 12'd100);
      tick();
      align(ha, hb);
      run(100, ha, hb);
      run(100, ha, hb);
      run(100, ha, hb);
      chk("de_steady_a", ha, 100);
      run(50, ha, hb);
      bus.DutyA = 12'd30;
      run(50, ha, hb);
      chk("de_cur_period_a", ha, 50);
      run(100, ha, hb);
      chk("de_30_a", ha, 30);
      chk("de_30_b", hb, 100);
      bus.DutyA = 12'd150;
      run(100, ha, hb);
      chk("de_150_p0", ha, 30);
      run(100, ha, hb);
      chk("de_150_p1", ha, 70);
      run(100, ha, hb);
      chk("de_150_p2", ha, 100);
      run(100, ha, hb);
      chk("de_150_p3", ha, 100);
      bus.DutyA = 12'd0;
      run(100, ha, hb);
      chk("de_0_p0", ha, 100);
      run(100, ha, hb);
      chk("de_0_p1", ha, 0);
      run(100, ha, hb);
      chk("de_0_p2", ha, 0);

      // 6. reset mid-DEAD (1011 sanitizes to 1000 and flags a fault)
      bus.Direction = 4'b1011;
      run(5, ha, hb);
      chk("rd_dead_before", bus.dead_active, 1'b1);
      chk("rd_fault_before", bus.shoot_fault, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("rd_async_hbridge", bus.hbridge_in, 4'b0000);
      chk("rd_async_pwm", {bus.pwm_a, bus.pwm_b}, 2'b00);
      chk("rd_async_dead", bus.dead_active, 1'b0);
      chk("rd_async_fault", bus.shoot_fault, 1'b0);
      tick();
      tick();
      bus.Direction = 4'b0000;
      rst_n = 1'b1;
      bad = 0;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (bus.hbridge_in !== 4'b0000 || bus.pwm_a !== 1'b0 || bus.pwm_b !== 1'b0 ||
             bus.dead_active !== 1'b0 || bus.shoot_fault !== 1'b0) bad++;
      end
      chk("rd_after_release_bad", bad, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
